// File: rtl/bit4_shift_mult.sv
// 4x4 unsigned shift-add multiplier with valid/ready handshakes on both sides.
// Every partial-sum addition goes through the single bit4_adder instance.

module bit4_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b};
endmodule

module bit4_shift_mult (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] product,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [3:0] q_q, q_d;
    logic [3:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;

    logic [3:0] add_s;
    logic       add_c;
    logic [3:0] psum;
    logic       pcarry;

    bit4_adder u_adder (
        .a    (acc_q),
        .b    (m_q),
        .s    (add_s),
        .cout (add_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        psum      = q_q[0] ? add_s : acc_q;
        pcarry    = q_q[0] & add_c;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // 9-bit right shift of {carry, sum, Q}: carry lands in ACC[3]
                acc_d = {pcarry, psum[3:1]};
                q_d   = {psum[0], q_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d   = DONE;
                    product_d = {pcarry, psum[3:1], psum[0], q_q[3:1]};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        product   = product_q;
    end
endmodule

// File: tb/tb_bit4_shift_mult.sv
// Directed and exhaustive checks for bit4_shift_mult: latency, backpressure,
// operand isolation during CALC, asynchronous reset abort.

module tb_bit4_shift_mult;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    bit4_shift_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents the pair for one edge, returns with in_valid low.
    task automatic accept(input logic [3:0] va, input logic [3:0] vb);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", int'(in_ready), 1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (already 1) until out_valid is seen.
    task automatic wait_done(input string name);
        int edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check({name, "_latency"}, edges, 5);
    endtask

    initial begin
        vec_t vecs[7];
        int   hs;
        vecs[0] = '{4'd3,  4'd4,  8'd12};
        vecs[1] = '{4'd0,  4'd5,  8'd0};
        vecs[2] = '{4'd9,  4'd2,  8'd18};
        vecs[3] = '{4'd10, 4'd10, 8'd100};
        vecs[4] = '{4'd15, 4'd15, 8'd225};
        vecs[5] = '{4'd7,  4'd0,  8'd0};
        vecs[6] = '{4'd1,  4'd13, 8'd13};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_product", int'(product), 0);
        #9 rst_n = 1'b1;
        tick();
        check("post_rst_idle", int'(busy), 0);

        // Directed table with out_ready held high
        for (int i = 0; i < 7; i++) begin
            accept(vecs[i].a, vecs[i].b);
            check("calc_busy", int'(busy), 1);
            check("calc_in_ready", int'(in_ready), 0);
            wait_done("vec");
            check("vec_product", int'(product), int'(vecs[i].exp));
            tick();
            check("vec_release_valid", int'(out_valid), 0);
            check("vec_release_ready", int'(in_ready), 1);
        end

        // Backpressure: 7*6 held for 10 cycles
        out_ready = 1'b0;
        accept(4'd7, 4'd6);
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", int'(out_valid), 1);
            check("bp_product", int'(product), 42);
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        check("bp_product_hold", int'(product), 42);

        // Operands change during CALC with in_valid held
        accept(4'd5, 4'd3);
        a        = 4'd15;
        b        = 4'd15;
        in_valid = 1'b1;
        wait_done("opchg");
        check("opchg_product", int'(product), 15);
        tick();
        check("opchg_no_same_edge", int'(busy), 0);
        tick();
        in_valid = 1'b0;
        check("opchg_second_accept", int'(busy), 1);
        wait_done("opchg2");
        check("opchg2_product", int'(product), 225);
        tick();

        // Reset mid-operation
        accept(4'd12, 4'd11);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_product", int'(product), 0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        accept(4'd2, 4'd2);
        wait_done("midrst");
        check("midrst_new_product", int'(product), 4);
        tick();

        // Exhaustive with random stalls
        hs = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                logic done;
                int   n;
                out_ready = 1'b0;
                accept(4'(ia), 4'(ib));
                wait_done("exh");
                check("exh_product", int'(product), ia * ib);
                done = 1'b0;
                n    = 0;
                while (!done && n < 40) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                    if (out_ready) begin
                        done = 1'b1;
                        hs++;
                        if (out_valid) begin
                            check("exh_release", int'(out_valid), 0);
                        end
                    end else if (product != 8'(ia * ib) || !out_valid) begin
                        check("exh_stall_hold", int'(product), ia * ib);
                    end
                end
            end
        end
        check("exh_handshakes", hs, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
